// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings and the default-slave state type used by the
// slave-side decoder/mux and its default slave.
`ifndef AHB_LITE_PKG_SV
`define AHB_LITE_PKG_SV

`ifndef W_BURST
`define W_BURST 3
`endif

package ahb_lite_pkg;

  localparam int W_BURST = `W_BURST;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no transfer.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

`endif

// File: rtl/ahb_lite_slave_mux_if.sv
// Bus bundle between the single AHB-lite master, the decoder/mux and the
// N_SLAVE attached peripherals.
`ifndef W_BURST
`define W_BURST 3
`endif

interface ahb_lite_slave_mux_if #(
  parameter int N_SLAVE = 4,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);

  logic [W_ADDR-1:0]         m_HADDR;
  logic [1:0]                m_HTRANS;
  logic                      m_HWRITE;
  logic [2:0]                m_HSIZE;
  logic [`W_BURST-1:0]       m_HBURST;
  logic [W_DATA-1:0]         m_HWDATA;
  logic                      m_HREADY;
  logic [1:0]                m_HRESP;
  logic [W_DATA-1:0]         m_HRDATA;

  logic [N_SLAVE-1:0]        sl_HSEL;
  logic [W_ADDR-1:0]         sl_HADDR;
  logic [1:0]                sl_HTRANS;
  logic                      sl_HWRITE;
  logic [2:0]                sl_HSIZE;
  logic [`W_BURST-1:0]       sl_HBURST;
  logic [W_DATA-1:0]         sl_HWDATA;
  logic                      sl_HREADY;
  logic [N_SLAVE-1:0]        sl_HREADYOUT;
  logic [N_SLAVE*2-1:0]      sl_HRESP;
  logic [N_SLAVE*W_DATA-1:0] sl_HRDATA;

  // The mux is the slave of the master port and drives the slave-side copies.
  modport slave (
    input  m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HBURST, m_HWDATA,
    input  sl_HREADYOUT, sl_HRESP, sl_HRDATA,
    output m_HREADY, m_HRESP, m_HRDATA,
    output sl_HSEL, sl_HADDR, sl_HTRANS, sl_HWRITE, sl_HSIZE, sl_HBURST,
    output sl_HWDATA, sl_HREADY
  );

  modport master (
    output m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HBURST, m_HWDATA,
    output sl_HREADYOUT, sl_HRESP, sl_HRDATA,
    input  m_HREADY, m_HRESP, m_HRDATA,
    input  sl_HSEL, sl_HADDR, sl_HTRANS, sl_HWRITE, sl_HSIZE, sl_HBURST,
    input  sl_HWDATA, sl_HREADY
  );

endinterface

// File: rtl/ahb_lite_default_slave.sv
// Default slave for unmapped accesses: two-cycle ERROR response plus
// error counter and last-error address capture.
//
// state   | meaning
// DS_IDLE | no error data phase in progress; ready, OKAY
// DS_ERR1 | first ERROR cycle, HREADY low
// DS_ERR2 | second ERROR cycle, HREADY high; next address may be accepted
module ahb_lite_default_slave
  import ahb_lite_pkg::*;
#(
  parameter int W_ADDR          = 32,
  parameter bit ERR_ON_UNMAPPED = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_i,
  input  logic [W_ADDR-1:0] haddr_i,
  output logic              hready_o,
  output logic [1:0]        hresp_o,
  output logic [15:0]       err_cnt_o,
  output logic [W_ADDR-1:0] err_addr_o
);

  ds_state_e         state_q, state_d;
  logic              err_start;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [W_ADDR-1:0] err_addr_q, err_addr_d;
  logic              err_req;

  assign err_req = req_i && ERR_ON_UNMAPPED;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= DS_IDLE;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hready_o  = 1'b1;
    hresp_o   = HRESP_OKAY;
    err_start = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (err_req) begin
          state_d   = DS_ERR1;
          err_start = 1'b1;
        end
      end
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        if (err_req) begin
          state_d   = DS_ERR1;
          err_start = 1'b1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_start) begin
      err_addr_d = haddr_i;
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: rtl/ahb_lite_slave_mux.sv
// Single-master AHB-lite address decoder and response multiplexer for N_SLAVE
// peripherals, with a built-in default slave for unmapped addresses.
module ahb_lite_slave_mux
  import ahb_lite_pkg::*;
#(
  parameter int                        N_SLAVE         = 4,
  parameter int                        W_ADDR          = 32,
  parameter int                        W_DATA          = 32,
  parameter logic [N_SLAVE*W_ADDR-1:0] ADDR_BASE       = {N_SLAVE{32'h0}},
  parameter logic [N_SLAVE*W_ADDR-1:0] ADDR_MASK       = {N_SLAVE{32'hF000_0000}},
  parameter bit                        ERR_ON_UNMAPPED = 1'b1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_lite_slave_mux_if.slave    bus,
  output logic [15:0]            err_cnt,
  output logic [W_ADDR-1:0]      err_addr
);

  localparam int W_SEL = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  typedef struct packed {
    logic             valid;
    logic             dflt;
    logic [W_SEL-1:0] idx;
  } dsel_t;

  logic               hit_any;
  logic [W_SEL-1:0]   win_idx;
  logic [N_SLAVE-1:0] hsel;
  logic               unmapped;
  logic               xfer;
  dsel_t              dsel_q, dsel_d;
  logic               ds_hready;
  logic [1:0]         ds_hresp;
  logic               hready;
  logic [1:0]         hresp;
  logic [W_DATA-1:0]  hrdata;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    win_idx = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if ((bus.m_HADDR & ADDR_MASK[i*W_ADDR +: W_ADDR]) ==
          (ADDR_BASE[i*W_ADDR +: W_ADDR] & ADDR_MASK[i*W_ADDR +: W_ADDR])) begin
        hit_any = 1'b1;
        win_idx = W_SEL'(i);
      end
    end
  end

  always_comb begin
    hsel = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      hsel[i] = hit_any && (win_idx == W_SEL'(i));
    end
  end

  assign unmapped = !hit_any;
  assign xfer     = trans_active(bus.m_HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= '0;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  always_comb begin
    dsel_d = dsel_q;
    if (hready) begin
      dsel_d.valid = xfer;
      dsel_d.dflt  = unmapped;
      dsel_d.idx   = win_idx;
    end
  end

  ahb_lite_default_slave #(
    .W_ADDR          (W_ADDR),
    .ERR_ON_UNMAPPED (ERR_ON_UNMAPPED)
  ) u_default_slave (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_i      (hready && unmapped && xfer),
    .haddr_i    (bus.m_HADDR),
    .hready_o   (ds_hready),
    .hresp_o    (ds_hresp),
    .err_cnt_o  (err_cnt),
    .err_addr_o (err_addr)
  );

  // Data-phase response depends only on registered dsel, never on the
  // current address, so mapped slaves see no added latency.
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    if (dsel_q.valid) begin
      if (dsel_q.dflt) begin
        hready = ds_hready;
        hresp  = ds_hresp;
      end else begin
        hready = bus.sl_HREADYOUT[dsel_q.idx];
        hresp  = bus.sl_HRESP[int'(dsel_q.idx)*2 +: 2];
        hrdata = bus.sl_HRDATA[int'(dsel_q.idx)*W_DATA +: W_DATA];
      end
    end
  end

  assign bus.m_HREADY  = hready;
  assign bus.m_HRESP   = hresp;
  assign bus.m_HRDATA  = hrdata;

  assign bus.sl_HSEL   = hsel;
  assign bus.sl_HADDR  = bus.m_HADDR;
  assign bus.sl_HTRANS = bus.m_HTRANS;
  assign bus.sl_HWRITE = bus.m_HWRITE;
  assign bus.sl_HSIZE  = bus.m_HSIZE;
  assign bus.sl_HBURST = bus.m_HBURST;
  assign bus.sl_HWDATA = bus.m_HWDATA;
  assign bus.sl_HREADY = hready;

endmodule

// File: tb/tb_ahb_lite_slave_mux.sv
// Bench for ahb_lite_slave_mux: an ERROR-on-unmapped instance and an OKAY-on-
// unmapped instance driven by the same master/slave stimulus.
module tb_ahb_lite_slave_mux;
  import ahb_lite_pkg::*;

  localparam int NS = 4;
  localparam int WA = 32;
  localparam int WD = 32;
  localparam logic [NS*WA-1:0] BASE = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*WA-1:0] MASK = {NS{32'hF000_0000}};

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [31:0]  m_haddr = '0;
  logic [1:0]   m_htrans = HTRANS_IDLE;
  logic         m_hwrite = 1'b0;
  logic [2:0]   m_hsize = 3'd2;
  logic [2:0]   m_hburst = 3'd0;
  logic [31:0]  m_hwdata = '0;
  logic [3:0]   s_ready = 4'hF;
  logic [7:0]   s_resp = '0;
  logic [127:0] s_rdata = '0;

  ahb_lite_slave_mux_if #(.N_SLAVE(NS), .W_ADDR(WA), .W_DATA(WD)) bus0 ();
  ahb_lite_slave_mux_if #(.N_SLAVE(NS), .W_ADDR(WA), .W_DATA(WD)) bus1 ();

  assign bus0.m_HADDR = m_haddr;   assign bus1.m_HADDR = m_haddr;
  assign bus0.m_HTRANS = m_htrans; assign bus1.m_HTRANS = m_htrans;
  assign bus0.m_HWRITE = m_hwrite; assign bus1.m_HWRITE = m_hwrite;
  assign bus0.m_HSIZE = m_hsize;   assign bus1.m_HSIZE = m_hsize;
  assign bus0.m_HBURST = m_hburst; assign bus1.m_HBURST = m_hburst;
  assign bus0.m_HWDATA = m_hwdata; assign bus1.m_HWDATA = m_hwdata;
  assign bus0.sl_HREADYOUT = s_ready; assign bus1.sl_HREADYOUT = s_ready;
  assign bus0.sl_HRESP = s_resp;   assign bus1.sl_HRESP = s_resp;
  assign bus0.sl_HRDATA = s_rdata; assign bus1.sl_HRDATA = s_rdata;

  logic [15:0] err_cnt0, err_cnt1;
  logic [31:0] err_addr0, err_addr1;

  ahb_lite_slave_mux #(.N_SLAVE(NS), .W_ADDR(WA), .W_DATA(WD), .ADDR_BASE(BASE),
                       .ADDR_MASK(MASK), .ERR_ON_UNMAPPED(1'b1)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0.slave), .err_cnt(err_cnt0), .err_addr(err_addr0));

  ahb_lite_slave_mux #(.N_SLAVE(NS), .W_ADDR(WA), .W_DATA(WD), .ADDR_BASE(BASE),
                       .ADDR_MASK(MASK), .ERR_ON_UNMAPPED(1'b0)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1.slave), .err_cnt(err_cnt1), .err_addr(err_addr1));

  // Reference model: per instance, what the current data phase targets and how
  // many ERROR cycles it still owes.
  bit          ph_valid [2];
  int          ph_slave [2];
  int          err_left [2];
  int unsigned m_cnt [2];
  logic [31:0] m_eaddr [2];
  bit          last_acc0 = 1'b1;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  hsel;
  } dec_vec_t;
  dec_vec_t dv [8];

  function automatic int target(input logic [31:0] a);
    int n;
    n = int'(a[31:28]);
    return (n >= 1 && n <= 4) ? n - 1 : -1;
  endfunction

  function automatic logic exp_ready(input int d);
    if (!ph_valid[d]) return 1'b1;
    if (ph_slave[d] >= 0) return s_ready[ph_slave[d]];
    return (err_left[d] == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [1:0] exp_resp(input int d);
    if (!ph_valid[d]) return 2'b00;
    if (ph_slave[d] >= 0) return s_resp[ph_slave[d]*2 +: 2];
    return (err_left[d] > 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input int d);
    if (ph_valid[d] && ph_slave[d] >= 0) return s_rdata[ph_slave[d]*32 +: 32];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph_valid[d] = 1'b0;
      ph_slave[d] = -1;
      err_left[d] = 0;
      m_cnt[d]    = 0;
      m_eaddr[d]  = '0;
    end
    last_acc0 = 1'b1;
  endtask

  task automatic model_update();
    logic r [2];
    int t;
    for (int d = 0; d < 2; d++) r[d] = exp_ready(d);
    t = target(m_haddr);
    for (int d = 0; d < 2; d++) begin
      if (r[d]) begin
        ph_valid[d] = m_htrans[1];
        ph_slave[d] = t;
        if (m_htrans[1] && t < 0 && d == 0) begin
          err_left[d] = 2;
          if (m_cnt[d] < 65535) m_cnt[d]++;
          m_eaddr[d] = m_haddr;
        end else begin
          err_left[d] = 0;
        end
      end else if (err_left[d] == 2) begin
        err_left[d] = 1;
      end
    end
    last_acc0 = r[0];
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic hr, input logic [1:0] rs, input logic [31:0] rd,
                           input logic [3:0] hs, input logic [15:0] cnt, input logic [31:0] ea,
                           input logic [31:0] sa, input logic sr, input logic [31:0] swd);
    int t;
    logic [3:0] ehs;
    t = target(m_haddr);
    ehs = (t >= 0) ? 4'(1 << t) : 4'h0;
    chk($sformatf("d%0d hready", d), 64'(hr), 64'(exp_ready(d)));
    chk($sformatf("d%0d hresp", d), 64'(rs), 64'(exp_resp(d)));
    chk($sformatf("d%0d hrdata", d), 64'(rd), 64'(exp_rdata(d)));
    chk($sformatf("d%0d hsel", d), 64'(hs), 64'(ehs));
    chk($sformatf("d%0d err_cnt", d), 64'(cnt), 64'(m_cnt[d]));
    chk($sformatf("d%0d err_addr", d), 64'(ea), 64'(m_eaddr[d]));
    chk($sformatf("d%0d sl_haddr", d), 64'(sa), 64'(m_haddr));
    chk($sformatf("d%0d sl_hready", d), 64'(sr), 64'(exp_ready(d)));
    chk($sformatf("d%0d sl_hwdata", d), 64'(swd), 64'(m_hwdata));
  endtask

  task automatic sample();
    @(negedge HCLK);
    check_dut(0, bus0.m_HREADY, bus0.m_HRESP, bus0.m_HRDATA, bus0.sl_HSEL, err_cnt0, err_addr0,
              bus0.sl_HADDR, bus0.sl_HREADY, bus0.sl_HWDATA);
    check_dut(1, bus1.m_HREADY, bus1.m_HRESP, bus1.m_HRDATA, bus1.sl_HSEL, err_cnt1, err_addr1,
              bus1.sl_HADDR, bus1.sl_HREADY, bus1.sl_HWDATA);
    chk("d0 sl_htrans", 64'(bus0.sl_HTRANS), 64'(m_htrans));
  endtask

  task automatic advance();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    m_htrans = HTRANS_IDLE;
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0] = '{32'h1000_0000, HTRANS_IDLE, 4'b0001};
    dv[1] = '{32'h2FFF_FFFC, HTRANS_BUSY, 4'b0010};
    dv[2] = '{32'h3000_0010, HTRANS_IDLE, 4'b0100};
    dv[3] = '{32'h4ABC_0000, HTRANS_IDLE, 4'b1000};
    dv[4] = '{32'h0000_0000, HTRANS_IDLE, 4'b0000};
    dv[5] = '{32'h5000_0000, HTRANS_IDLE, 4'b0000};
    dv[6] = '{32'hF000_0000, HTRANS_BUSY, 4'b0000};
    dv[7] = '{32'h4FFF_FFFF, HTRANS_IDLE, 4'b1000};

    model_reset();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst hready", 64'(bus0.m_HREADY), 64'h1);
    chk("rst hresp", 64'(bus0.m_HRESP), 64'h0);
    chk("rst hrdata", 64'(bus0.m_HRDATA), 64'h0);
    chk("rst err_cnt", 64'(err_cnt0), 64'h0);
    chk("rst err_addr", 64'(err_addr0), 64'h0);
    HRESETn = 1'b1;
    advance();

    // decode table, non-transfer HTRANS so no data phases start
    for (int i = 0; i < 8; i++) begin
      m_haddr = dv[i].addr;
      m_htrans = dv[i].trans;
      sample();
      chk($sformatf("dec%0d hsel0", i), 64'(bus0.sl_HSEL), 64'(dv[i].hsel));
      chk($sformatf("dec%0d hsel1", i), 64'(bus1.sl_HSEL), 64'(dv[i].hsel));
      advance();
    end

    // single read from slave 2
    s_ready = 4'hF; s_resp = '0;
    s_rdata[2*32 +: 32] = 32'hCAFE_0001;
    m_haddr = 32'h3000_0010; m_htrans = HTRANS_NONSEQ; m_hwrite = 1'b0;
    sample();
    chk("t1 hsel", 64'(bus0.sl_HSEL), 64'h4);
    advance();
    m_htrans = HTRANS_IDLE; m_haddr = 32'h0;
    sample();
    chk("t1 rdata", 64'(bus0.m_HRDATA), 64'hCAFE_0001);
    chk("t1 ready", 64'(bus0.m_HREADY), 64'h1);
    chk("t1 resp", 64'(bus0.m_HRESP), 64'h0);
    advance();

    // write to slave 0 with two wait states
    m_haddr = 32'h1000_0000; m_htrans = HTRANS_NONSEQ; m_hwrite = 1'b1;
    sample();
    advance();
    m_htrans = HTRANS_IDLE; m_haddr = 32'h2000_0000; m_hwdata = 32'h5A5A_1234;
    s_ready = 4'b1110;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk($sformatf("t2 wait%0d ready", k), 64'(bus0.m_HREADY), 64'h0);
      chk($sformatf("t2 wait%0d hwdata", k), 64'(bus0.sl_HWDATA), 64'h5A5A_1234);
      advance();
    end
    s_ready = 4'hF;
    sample();
    chk("t2 done ready", 64'(bus0.m_HREADY), 64'h1);
    advance();
    m_hwrite = 1'b0;

    // single unmapped access
    s_rdata = {4{32'hDEAD_BEEF}};
    m_haddr = 32'h9000_0000; m_htrans = HTRANS_NONSEQ;
    sample();
    advance();
    m_htrans = HTRANS_IDLE; m_haddr = 32'h0;
    sample();
    chk("t3 err1 ready", 64'(bus0.m_HREADY), 64'h0);
    chk("t3 err1 resp", 64'(bus0.m_HRESP), 64'h1);
    chk("t3 ok1 ready", 64'(bus1.m_HREADY), 64'h1);
    advance();
    sample();
    chk("t3 err2 ready", 64'(bus0.m_HREADY), 64'h1);
    chk("t3 err2 resp", 64'(bus0.m_HRESP), 64'h1);
    advance();
    sample();
    chk("t3 after resp", 64'(bus0.m_HRESP), 64'h0);
    chk("t3 err_cnt", 64'(err_cnt0), 64'h1);
    chk("t3 err_addr", 64'(err_addr0), 64'h9000_0000);
    chk("t3 err_cnt1", 64'(err_cnt1), 64'h0);
    advance();

    // back-to-back unmapped, second accepted in DS_ERR2
    do_reset();
    m_haddr = 32'h9000_0000; m_htrans = HTRANS_NONSEQ;
    sample();
    advance();
    m_haddr = 32'hA000_0004;
    sample();
    chk("t4 a err1 ready", 64'(bus0.m_HREADY), 64'h0);
    chk("t4 a err1 resp", 64'(bus0.m_HRESP), 64'h1);
    advance();
    sample();
    chk("t4 a err2 ready", 64'(bus0.m_HREADY), 64'h1);
    chk("t4 a err2 resp", 64'(bus0.m_HRESP), 64'h1);
    advance();
    m_htrans = HTRANS_IDLE; m_haddr = 32'h0;
    sample();
    chk("t4 b err1 ready", 64'(bus0.m_HREADY), 64'h0);
    chk("t4 b err1 resp", 64'(bus0.m_HRESP), 64'h1);
    advance();
    sample();
    chk("t4 b err2 ready", 64'(bus0.m_HREADY), 64'h1);
    chk("t4 b err2 resp", 64'(bus0.m_HRESP), 64'h1);
    advance();
    sample();
    chk("t4 err_cnt", 64'(err_cnt0), 64'h2);
    chk("t4 err_addr", 64'(err_addr0), 64'hA000_0004);
    advance();

    // IDLE to unmapped, and OKAY-on-unmapped build
    do_reset();
    m_haddr = 32'h9000_0000; m_htrans = HTRANS_IDLE;
    sample();
    advance();
    sample();
    chk("t5 idle ready", 64'(bus0.m_HREADY), 64'h1);
    chk("t5 idle resp", 64'(bus0.m_HRESP), 64'h0);
    chk("t5 idle rdata", 64'(bus0.m_HRDATA), 64'h0);
    chk("t5 idle cnt", 64'(err_cnt0), 64'h0);
    m_haddr = 32'hB000_0000; m_htrans = HTRANS_NONSEQ; m_hwrite = 1'b1;
    advance();
    m_htrans = HTRANS_IDLE; m_haddr = 32'h0; m_hwrite = 1'b0;
    sample();
    chk("t5 ok ready", 64'(bus1.m_HREADY), 64'h1);
    chk("t5 ok resp", 64'(bus1.m_HRESP), 64'h0);
    chk("t5 ok rdata", 64'(bus1.m_HRDATA), 64'h0);
    chk("t5 ok cnt", 64'(err_cnt1), 64'h0);
    for (int k = 0; k < 3; k++) begin
      advance();
      sample();
    end
    advance();

    // asynchronous reset during DS_ERR1
    do_reset();
    m_haddr = 32'h9000_0000; m_htrans = HTRANS_NONSEQ;
    sample();
    advance();
    m_htrans = HTRANS_IDLE; m_haddr = 32'h0;
    sample();
    chk("t6 in err1", 64'(bus0.m_HREADY), 64'h0);
    #1;
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("t6 rst ready", 64'(bus0.m_HREADY), 64'h1);
    chk("t6 rst resp", 64'(bus0.m_HRESP), 64'h0);
    chk("t6 rst cnt", 64'(err_cnt0), 64'h0);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    model_update();
    #1;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk($sformatf("t6 post%0d resp", k), 64'(bus0.m_HRESP), 64'h0);
      chk($sformatf("t6 post%0d ready", k), 64'(bus0.m_HREADY), 64'h1);
      advance();
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (last_acc0) begin
        int region;
        logic [3:0] nib;
        region = int'($urandom_range(0, 9));
        if (region < 6) nib = 4'(region % 4 + 1);
        else            nib = 4'($urandom_range(5, 15));
        if (region == 9) nib = 4'h0;
        m_haddr = {nib, 28'($urandom)};
        m_htrans = 2'($urandom_range(0, 3));
        m_hwrite = 1'($urandom);
        m_hsize = 3'($urandom_range(0, 2));
        m_hburst = 3'($urandom);
      end
      m_hwdata = $urandom;
      for (int i = 0; i < 4; i++) s_ready[i] = ($urandom_range(0, 3) != 0);
      s_resp = 8'($urandom);
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
